mor1kx_dpram_fifo_ctrl: RTL and testbench
=========================================

Name: mor1kx_dpram_fifo_ctrl

Overview:
Single-clock first-word-fall-through (FWFT) FIFO controller built around the team's simple dual-port RAM primitive. The RAM has separate read and write ports, a 1-cycle registered read, and write-to-read bypass enabled.
- The controller sequences RAM write and read addresses and enables, keeps occupancy, and presents the head word on rd_data whenever empty is low.
- Used as a generic buffer between pipeline stages, e.g. store buffer or bus-response queues.

Parameters:
DEPTH_WIDTH  4   log2 of capacity; capacity = 2^DEPTH_WIDTH entries; RAM ADDR_WIDTH = DEPTH_WIDTH
DATA_WIDTH  32  entry width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of all contents
wr_en  input  1  push request; wr_data written when accepted
wr_data  input  DATA_WIDTH  push data
full  output  1  high when count == 2^DEPTH_WIDTH
rd_en  input  1  pop request; consumes the head word when accepted
rd_data  output  DATA_WIDTH  head word; valid only while empty is low
empty  output  1  high when no head word is presented
count  output  DEPTH_WIDTH+1  total entries held, including the presented head

Behaviour:
- Reset (rst_n low, async):
  - wptr = 0, rptr = 0, count = 0.
  - head-valid flag = 0, so empty = 1 and full = 0.
  - rd_data is don't-care.
- Acceptance rules, all evaluated on pre-edge state:
  - push_ok = wr_en & ~full.
  - pop_ok = rd_en & ~empty.
  - Push while full: ignored, no state change.
  - Pop while empty: ignored.
- Simultaneous push and pop:
  - When full: only the pop is accepted; the push is not accepted even though a slot frees.
  - When empty: only the push is accepted.
  - Otherwise both are accepted and count is unchanged.
- Count update: count += push_ok - pop_ok. It saturates implicitly by the acceptance rules and never exceeds 2^DEPTH_WIDTH.
- RAM write port:
  - we = push_ok, waddr = wptr, din = wr_data.
  - wptr increments modulo 2^DEPTH_WIDTH on push_ok.
- RAM read port (prefetch):
  - re = fetch, where fetch = (~head_valid | pop_ok) & (ram_words > 0 | push_ok).
  - ram_words = count - head_valid, i.e. entries in RAM not yet fetched.
  - raddr = rptr; rptr increments modulo 2^DEPTH_WIDTH on fetch.
  - When ram_words == 0 and push_ok, raddr == waddr and the RAM bypass delivers wr_data.
- Head register:
  - head_valid is set on the edge where fetch occurs.
  - head_valid is cleared on the edge where pop_ok occurs without fetch.
  - empty = ~head_valid; rd_data = RAM dout.
- Latency:
  - Push into an empty FIFO at edge N gives empty = 0 and rd_data = pushed word in the cycle after edge N (1 cycle).
  - Back-to-back pops of a non-empty FIFO sustain 1 word per cycle with no bubble.
- Wrap-around: pointers wrap silently; full and empty are derived from count and head_valid, never from pointer compare.
- flush: synchronous, same effect as reset. It has priority over wr_en and rd_en in the same cycle, so no write and no read are issued.
- Async reset mid-operation: all state clears immediately; RAM contents are not cleared and are unobservable.

Optional Feature:
MOR1KX_DPRAM_FIFO_ERR_EN
- With the macro defined:
  - Extra outputs overflow (1 bit) and underflow (1 bit), both sticky.
  - overflow is set on wr_en & full; underflow is set on rd_en & empty.
  - Both are cleared by rst_n low or by flush; flush wins over a same-cycle set.
- Without the macro: the ports and logic are absent. Ignored requests leave no trace.

Test Plan:
- Reset then idle 5 cycles -> empty = 1, full = 0, count = 0 throughout.
- Push 0xA5A5_0001 into empty FIFO at cycle 0 -> cycle 1: empty = 0, rd_data = 0xA5A5_0001, count = 1; pop at cycle 1 -> cycle 2: empty = 1, count = 0.
- DEPTH_WIDTH = 4: push 0..15 -> full = 1, count = 16; push 0xDEAD ignored (overflow = 1 if MOR1KX_DPRAM_FIFO_ERR_EN); pop 16 times back-to-back -> rd_data 0..15 in order, one word per cycle, then empty = 1.
- Push and pop every cycle for 40 cycles from count = 3 (pointers wrap twice) -> count stays 3, output order equals input order, no bubbles.
- Full with wr_en and rd_en both high -> pop accepted, push rejected, count 16 -> 15. Empty with both high -> push accepted, count 0 -> 1, empty = 0 next cycle.
- Count = 7: assert flush together with wr_en and rd_en -> next cycle count = 0, empty = 1; subsequent push of 0x1234 appears on rd_data 1 cycle later. Assert rst_n low mid-burst -> empty = 1 and count = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// mor1kx_dpram_fifo_ctrl: single-clock first-word-fall-through FIFO
// controller wrapped around a simple dual-port RAM with a 1-cycle
// registered read and write-to-read bypass.
// Optional macro MOR1KX_DPRAM_FIFO_ERR_EN adds sticky overflow/underflow
// outputs; without it those ports and their logic are absent.
`timescale 1ns/1ps

module mor1kx_dpram_fifo_ram #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_dout;

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_din;
    end

    // Registered read; holds its value when not enabled, same-address write bypasses
    always_ff @(posedge i_clk) begin
        if (i_re)
            r_dout <= (i_we && (i_waddr == i_raddr)) ? i_din : r_mem[i_raddr];
    end

    assign o_dout = r_dout;

endmodule

module mor1kx_dpram_fifo_ctrl #(
    parameter int unsigned DEPTH_WIDTH = 4,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_wr_en,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,
    output logic                   o_full,
    input  logic                   i_rd_en,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    output logic                   o_empty,
`ifdef MOR1KX_DPRAM_FIFO_ERR_EN
    output logic                   o_overflow,
    output logic                   o_underflow,
`endif
    output logic [DEPTH_WIDTH:0]   o_count
);

    localparam logic [DEPTH_WIDTH:0] CAPACITY = {1'b1, {DEPTH_WIDTH{1'b0}}};

    logic [DEPTH_WIDTH-1:0] r_wptr;
    logic [DEPTH_WIDTH-1:0] r_rptr;
    logic [DEPTH_WIDTH:0]   r_count;
    logic                   r_head_valid;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push_ok;
    logic                   w_pop_ok;
    logic                   w_fetch;
    logic [DEPTH_WIDTH:0]   w_ram_words;
    logic                   w_ram_we;
    logic                   w_ram_re;
    logic [DATA_WIDTH-1:0]  w_ram_dout;

    assign w_full      = (r_count == CAPACITY);
    assign w_empty     = ~r_head_valid;
    assign w_push_ok   = i_wr_en & ~w_full;
    assign w_pop_ok    = i_rd_en & ~w_empty;
    // Words written to RAM but not yet fetched into the head register
    assign w_ram_words = r_count - {{DEPTH_WIDTH{1'b0}}, r_head_valid};
    // Refill the head when it is empty or being consumed; with nothing in RAM
    // a same-cycle push reaches the head through the RAM bypass
    assign w_fetch     = (~r_head_valid | w_pop_ok) & ((w_ram_words != '0) | w_push_ok);
    // Flush suppresses all RAM traffic in its cycle
    assign w_ram_we    = w_push_ok & ~i_flush;
    assign w_ram_re    = w_fetch & ~i_flush;

    mor1kx_dpram_fifo_ram #(
        .ADDR_WIDTH (DEPTH_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_re    (w_ram_re),
        .i_raddr (r_rptr),
        .i_we    (w_ram_we),
        .i_waddr (r_wptr),
        .i_din   (i_wr_data),
        .o_dout  (w_ram_dout)
    );

    // Pointer, occupancy and head-valid bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
        end else if (i_flush) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + 1'b1;
            if (w_fetch)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{DEPTH_WIDTH{1'b0}}, w_push_ok}
                               - {{DEPTH_WIDTH{1'b0}}, w_pop_ok};
            if (w_fetch)
                r_head_valid <= 1'b1;
            else if (w_pop_ok)
                r_head_valid <= 1'b0;
        end
    end

`ifdef MOR1KX_DPRAM_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags for rejected requests; flush beats a same-cycle set
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_en & w_full)
                r_overflow <= 1'b1;
            if (i_rd_en & w_empty)
                r_underflow <= 1'b1;
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`endif

    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;
    assign o_rd_data = w_ram_dout;

endmodule

// File: tb/tb_mor1kx_dpram_fifo_ctrl.sv
// Directed self-checking bench for mor1kx_dpram_fifo_ctrl (DEPTH_WIDTH=4).
`timescale 1ns/1ps

module tb_mor1kx_dpram_fifo_ctrl;

    localparam int unsigned DW = 4;
    localparam int unsigned WW = 32;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [WW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [WW-1:0] rd_data;
    logic          empty;
    logic [DW:0]   count;
`ifdef MOR1KX_DPRAM_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    int checks = 0;
    int errors = 0;

    mor1kx_dpram_fifo_ctrl #(
        .DEPTH_WIDTH (DW),
        .DATA_WIDTH  (WW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_flush   (flush),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .o_full    (full),
        .i_rd_en   (rd_en),
        .o_rd_data (rd_data),
        .o_empty   (empty),
`ifdef MOR1KX_DPRAM_FIFO_ERR_EN
        .o_overflow  (overflow),
        .o_underflow (underflow),
`endif
        .o_count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #12;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd0);
        chk("rst_count", 64'(count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_empty", 64'(empty), 64'd1);
            chk("idle_full",  64'(full),  64'd0);
            chk("idle_count", 64'(count), 64'd0);
        end

        // Single push into empty FIFO, then pop
        wr_en = 1'b1; wr_data = 32'hA5A5_0001;
        tick();
        wr_en = 1'b0;
        chk("one_empty", 64'(empty),   64'd0);
        chk("one_data",  64'(rd_data), 64'hA5A5_0001);
        chk("one_count", 64'(count),   64'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("one_pop_empty", 64'(empty), 64'd1);
        chk("one_pop_count", 64'(count), 64'd0);

        // Fill to capacity
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = WW'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("fill_full",  64'(full),    64'd1);
        chk("fill_count", 64'(count),   64'd16);
        chk("fill_head",  64'(rd_data), 64'd0);
        // Push while full is ignored
        wr_en = 1'b1; wr_data = 32'h0000_DEAD;
        tick();
        wr_en = 1'b0;
        chk("ovf_count", 64'(count),   64'd16);
        chk("ovf_head",  64'(rd_data), 64'd0);
`ifdef MOR1KX_DPRAM_FIFO_ERR_EN
        chk("ovf_flag",  64'(overflow), 64'd1);
`endif
        // Back-to-back drain, one word per cycle
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_empty", 64'(empty),   64'd0);
            chk("drain_data",  64'(rd_data), 64'(i));
            tick();
        end
        rd_en = 1'b0;
        chk("drain_done_empty", 64'(empty), 64'd1);
        chk("drain_done_count", 64'(count), 64'd0);

        // Streaming push+pop from count = 3 across pointer wraps
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = WW'(100 + i);
            tick();
        end
        wr_en = 1'b1; rd_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wr_data = WW'(103 + k);
            chk("stream_count", 64'(count),   64'd3);
            chk("stream_data",  64'(rd_data), 64'(100 + k));
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stream_tail", 64'(rd_data), 64'(140 + i));
            tick();
        end
        rd_en = 1'b0;
        chk("stream_end_empty", 64'(empty), 64'd1);

        // Full with push and pop: only pop accepted
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = WW'(200 + i);
            tick();
        end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h0000_BEEF;
        tick();
        wr_en = 1'b0;
        chk("fullboth_count", 64'(count),   64'd15);
        chk("fullboth_full",  64'(full),    64'd0);
        for (int i = 0; i < 15; i++) begin
            chk("fullboth_data", 64'(rd_data), 64'(201 + i));
            tick();
        end
        chk("fullboth_empty", 64'(empty), 64'd1);
        // Empty with push and pop: only push accepted
        wr_en = 1'b1; wr_data = 32'h0000_0077;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("emptyboth_count", 64'(count),   64'd1);
        chk("emptyboth_empty", 64'(empty),   64'd0);
        chk("emptyboth_data",  64'(rd_data), 64'h77);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("emptyboth_pop", 64'(empty), 64'd1);

        // Flush beats same-cycle push and pop
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_data = WW'(300 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("preflush_count", 64'(count), 64'd7);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h0000_0999;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        wr_en = 1'b1; wr_data = 32'h0000_1234;
        tick();
        wr_en = 1'b0;
        chk("postflush_empty", 64'(empty),   64'd0);
        chk("postflush_data",  64'(rd_data), 64'h1234);
        chk("postflush_count", 64'(count),   64'd1);

        // Async reset in the middle of a burst clears state before the next edge
        wr_en = 1'b1; wr_data = 32'h0000_0500;
        tick();
        wr_data = 32'h0000_0501;
        tick();
        chk("preasync_count", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_empty", 64'(empty), 64'd1);
        chk("async_count", 64'(count), 64'd0);
        chk("async_full",  64'(full),  64'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("postasync_empty", 64'(empty), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
